// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and helpers for the multi-port register file.
package regfile_mp_pkg;

    localparam int ZERO_REG = 0;
    localparam int MAX_NRD  = 4;
    localparam int MAX_NWR  = 2;

    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_mp_rdport.sv
// regfile_mp_rdport: one combinational read port with zero-register override.
// REGFILE_MP_BYPASS_EN adds same-cycle forwarding from the write buses.
module regfile_mp_rdport
    import regfile_mp_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int NWR   = 1,
    localparam int AW   = addr_w(DEPTH)
) (
    input  logic              i_rst_n,
    input  logic [AW-1:0]     i_rd_addr,
    input  logic [DW-1:0]     i_mem [DEPTH],
    input  logic [DEPTH-1:0]  i_busy,
    input  logic [NWR-1:0]    i_wr_en,
    input  logic [NWR*AW-1:0] i_wr_addr,
    input  logic [NWR*DW-1:0] i_wr_data,
    input  logic              i_bsy_set,
    input  logic [AW-1:0]     i_bsy_addr,
    output logic [DW-1:0]     o_rd_data,
    output logic              o_rd_busy
);

    logic [DW-1:0] w_data;
    logic          w_busy;
    logic          w_is_zero;

    assign w_is_zero = (i_rd_addr == AW'(ZERO_REG));

`ifdef REGFILE_MP_BYPASS_EN
    // Ascending loop lets the highest enabled write port win, as in storage.
    always_comb begin
        w_data = i_mem[i_rd_addr];
        w_busy = i_busy[i_rd_addr];
        for (int k = 0; k < NWR; k++) begin
            if (i_wr_en[k] && (i_wr_addr[k*AW +: AW] == i_rd_addr)) begin
                w_data = i_wr_data[k*DW +: DW];
                w_busy = i_bsy_set && (i_bsy_addr == i_rd_addr);
            end
        end
    end
`else
    logic w_unused_bypass;

    assign w_unused_bypass = ^{i_wr_en, i_wr_addr, i_wr_data,
                               i_bsy_set, i_bsy_addr};

    always_comb begin
        w_data = i_mem[i_rd_addr];
        w_busy = i_busy[i_rd_addr];
    end
`endif

    // Reset gating keeps forwarded write data from leaking out during reset.
    always_comb begin
        o_rd_data = w_data;
        o_rd_busy = w_busy;
        if (w_is_zero || !i_rst_n) begin
            o_rd_data = '0;
            o_rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with async clear and busy scoreboard.
// Macro REGFILE_MP_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    input  logic              bsy_set,
    input  logic [AW-1:0]     bsy_addr
);

    if (NRD < 1 || NRD > MAX_NRD) begin : g_bad_nrd
        $error("regfile_mp: NRD out of range");
    end
    if (NWR < 1 || NWR > MAX_NWR) begin : g_bad_nwr
        $error("regfile_mp: NWR out of range");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("regfile_mp: DEPTH must be a power of two >= 2");
    end

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_we;
    logic [DW-1:0]    w_wd [DEPTH];
    logic [DEPTH-1:0] w_set;

    // Later ports overwrite earlier ones, so port 1 wins a conflict.
    always_comb begin
        w_we = '0;
        for (int r = 0; r < DEPTH; r++) begin
            w_wd[r] = '0;
        end
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k]) begin
                w_we[wr_addr[k*AW +: AW]] = 1'b1;
                w_wd[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
            end
        end
        w_we[ZERO_REG] = 1'b0;
    end

    always_comb begin
        w_set = '0;
        if (bsy_set) begin
            w_set[bsy_addr] = 1'b1;
        end
        w_set[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (w_we[r]) begin
                    r_mem[r] <= w_wd[r];
                end
            end
        end
    end

    // A new producer's set outranks the retiring writer's clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_we) | w_set;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_mp_rdport #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .NWR   (NWR)
        ) u_rdport (
            .i_rst_n    (rst_n),
            .i_rd_addr  (rd_addr[i*AW +: AW]),
            .i_mem      (r_mem),
            .i_busy     (r_busy),
            .i_wr_en    (wr_en),
            .i_wr_addr  (wr_addr),
            .i_wr_data  (wr_data),
            .i_bsy_set  (bsy_set),
            .i_bsy_addr (bsy_addr),
            .o_rd_data  (rd_data[i*DW +: DW]),
            .o_rd_busy  (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table-driven bench for regfile_mp (4 read, 2 write).
// Expectations follow REGFILE_MP_BYPASS_EN when it is defined.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 4;
    localparam int NWR   = 2;
    localparam int AW    = 5;
`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              bsy_set;
    logic [AW-1:0]     bsy_addr;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_mp #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .bsy_set  (bsy_set),
        .bsy_addr (bsy_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   we;
        logic [9:0]   wa;
        logic [63:0]  wd;
        logic         bs;
        logic [4:0]   ba;
        logic [19:0]  ra;
        logic [127:0] ed;
        logic [3:0]   eb;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rdd(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    task automatic drive(input logic [1:0] we, input logic [9:0] wa,
                         input logic [63:0] wd, input logic bs,
                         input logic [4:0] ba, input logic [19:0] ra);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        bsy_set  = bs;
        bsy_addr = ba;
        rd_addr  = ra;
    endtask

    task automatic idle();
        wr_en   = '0;
        bsy_set = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        // {port1,port0} for writes, {port3..port0} for reads
        tbl[0]  = '{2'b01, {5'd0, 5'd3}, {32'h0, 32'h77}, 1'b0, 5'd0,
                    {5'd0, 5'd3, 5'd3, 5'd3},
                    {32'h0, 32'h77, 32'h77, 32'h77}, 4'b0000};
        tbl[1]  = '{2'b11, {5'd7, 5'd7}, {32'h5555, 32'hAAAA}, 1'b0, 5'd0,
                    {5'd0, 5'd7, 5'd3, 5'd7},
                    {32'h0, 32'h5555, 32'h77, 32'h5555}, 4'b0000};
        tbl[2]  = '{2'b10, {5'd0, 5'd0}, {32'hFFFFFFFF, 32'h0}, 1'b1, 5'd0,
                    {5'd0, 5'd0, 5'd0, 5'd0},
                    {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000};
        tbl[3]  = '{2'b00, {5'd0, 5'd0}, {32'h0, 32'h0}, 1'b1, 5'd9,
                    {5'd7, 5'd3, 5'd9, 5'd9},
                    {32'h5555, 32'h77, 32'h0, 32'h0}, 4'b0011};
        tbl[4]  = '{2'b01, {5'd0, 5'd9}, {32'h0, 32'h42}, 1'b0, 5'd0,
                    {5'd0, 5'd9, 5'd3, 5'd9},
                    {32'h0, 32'h42, 32'h77, 32'h42}, 4'b0000};
        tbl[5]  = '{2'b10, {5'd9, 5'd0}, {32'h42, 32'h0}, 1'b1, 5'd9,
                    {5'd9, 5'd9, 5'd9, 5'd9},
                    {32'h42, 32'h42, 32'h42, 32'h42}, 4'b1111};
        tbl[6]  = '{2'b00, {5'd0, 5'd0}, {32'h0, 32'h0}, 1'b1, 5'd9,
                    {5'd9, 5'd9, 5'd9, 5'd9},
                    {32'h42, 32'h42, 32'h42, 32'h42}, 4'b1111};
        tbl[7]  = '{2'b11, {5'd21, 5'd20}, {32'hABCD, 32'h1234}, 1'b0, 5'd0,
                    {5'd0, 5'd9, 5'd21, 5'd20},
                    {32'h0, 32'h42, 32'hABCD, 32'h1234}, 4'b0100};
        tbl[8]  = '{2'b01, {5'd0, 5'd9}, {32'h0, 32'h99}, 1'b1, 5'd10,
                    {5'd21, 5'd20, 5'd10, 5'd9},
                    {32'hABCD, 32'h1234, 32'h0, 32'h99}, 4'b0010};
        tbl[9]  = '{2'b11, {5'd3, 5'd3}, {32'hFFFFFFFF, 32'h1}, 1'b0, 5'd0,
                    {5'd0, 5'd31, 5'd10, 5'd3},
                    {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 4'b0010};
        tbl[10] = '{2'b01, {5'd11, 5'd11}, {32'h6, 32'h5}, 1'b0, 5'd0,
                    {5'd11, 5'd11, 5'd3, 5'd10},
                    {32'h5, 32'h5, 32'hFFFFFFFF, 32'h0}, 4'b0001};

        // Reset state, with a write held active to prove it is ignored
        rst_n = 1'b0;
        drive(2'b11, {5'd4, 5'd5}, {32'h44, 32'h55}, 1'b1, 5'd5,
              {5'd0, 5'd4, 5'd5, 5'd1});
        #12;
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("rst_d%0d", i), rdd(i), 32'h0);
        end
        chk("rst_busy", 32'(rd_busy), 32'h0);
        idle();
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_r5", rdd(1), 32'h0);
        chk("post_rst_busy", 32'(rd_busy), 32'h0);

        for (int n = 0; n < 11; n++) begin
            drive(tbl[n].we, tbl[n].wa, tbl[n].wd, tbl[n].bs, tbl[n].ba,
                  tbl[n].ra);
            tick();
            for (int i = 0; i < NRD; i++) begin
                chk($sformatf("v%0d_d%0d", n, i), rdd(i), tbl[n].ed[i*32 +: 32]);
            end
            chk($sformatf("v%0d_busy", n), 32'(rd_busy), 32'(tbl[n].eb));
        end

        // Asynchronous reset between edges, with a write in flight
        drive(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 1'b1, 5'd5,
              {5'd20, 5'd9, 5'd6, 5'd5});
        tick();
        chk("r5_wr", rdd(0), 32'hDEADBEEF);
        chk("r5_busy", 32'(rd_busy), 32'h1);
        drive(2'b01, {5'd0, 5'd6}, {32'h0, 32'h66}, 1'b0, 5'd0,
              {5'd20, 5'd9, 5'd6, 5'd5});
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("arst_d%0d", i), rdd(i), 32'h0);
        end
        chk("arst_busy", 32'(rd_busy), 32'h0);
        idle();
        #1 rst_n = 1'b1;
        tick();
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("arst_post_d%0d", i), rdd(i), 32'h0);
        end
        drive(2'b01, {5'd0, 5'd5}, {32'h0, 32'h1234}, 1'b0, 5'd0,
              {5'd20, 5'd9, 5'd6, 5'd5});
        tick();
        chk("r5_after_rst", rdd(0), 32'h1234);

        // Same-cycle read of a register being written
        drive(2'b00, '0, '0, 1'b1, 5'd12, {5'd0, 5'd12, 5'd12, 5'd12});
        tick();
        chk("r12_busy", 32'(rd_busy), 32'h7);
        drive(2'b01, {5'd0, 5'd12}, {32'h0, 32'hCAFE}, 1'b0, 5'd0,
              {5'd0, 5'd12, 5'd12, 5'd12});
        #1;
        chk("byp_d0", rdd(0), BYP ? 32'hCAFE : 32'h0);
        chk("byp_d3", rdd(3), 32'h0);
        chk("byp_busy", 32'(rd_busy), BYP ? 32'h0 : 32'h7);
        tick();
        chk("byp_next_d0", rdd(0), 32'hCAFE);
        chk("byp_next_busy", 32'(rd_busy), 32'h0);

        drive(2'b11, {5'd13, 5'd13}, {32'hBB, 32'hAA}, 1'b0, 5'd0,
              {5'd0, 5'd0, 5'd0, 5'd13});
        #1;
        chk("byp_prio", rdd(0), BYP ? 32'hBB : 32'h0);
        tick();
        chk("prio_next", rdd(0), 32'hBB);

        drive(2'b01, {5'd0, 5'd14}, {32'h0, 32'h14}, 1'b1, 5'd14,
              {5'd0, 5'd0, 5'd0, 5'd14});
        #1;
        chk("byp_set_busy", 32'(rd_busy), BYP ? 32'h1 : 32'h0);
        tick();
        chk("set_next_d0", rdd(0), 32'h14);
        chk("set_next_busy", 32'(rd_busy), 32'h1);

        drive(2'b10, {5'd0, 5'd0}, {32'hFFFFFFFF, 32'h0}, 1'b1, 5'd0,
              {5'd0, 5'd0, 5'd0, 5'd0});
        #1;
        chk("byp_r0", rdd(0), 32'h0);
        chk("byp_r0_busy", 32'(rd_busy), 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file: the next-generation datapath register file for the single-cycle and upcoming pipelined cores.
- Generalised in data width, depth, read-port count and write-port count.
- Adds an asynchronous clear, deterministic write-conflict priority, and a per-register busy scoreboard for the pipeline hazard unit.
- Sits between decode (read ports, busy query) and writeback (write ports).

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, ≥ 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*DW  packed read data, combinational.
- rd_busy  out  NRD  busy flag of the register addressed by each read port, combinational.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  packed write addresses.
- wr_data  in  NWR*DW  packed write data.
- bsy_set  in  1  mark register bsy_addr busy (producer issued).
- bsy_addr  in  AW  register to mark busy.

Behaviour:
- Reset:
  - rst_n low asynchronously clears every register to 0 and every busy bit to 0.
  - While rst_n is low, rd_data is all zero and rd_busy is all zero.
  - Writes and bsy_set are ignored until the first rising edge after rst_n deasserts.
  - Reset mid-write: the write is lost; the register reads 0.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to it and bsy_set with bsy_addr==0 are discarded.
- Read:
  - Combinational, zero latency.
  - rd_data[i] = reg[rd_addr[i]] as stored at the last edge (see Optional Feature for same-cycle forwarding).
  - Any number of read ports may hit the same address.
- Write:
  - Takes effect on the rising edge of clk when wr_en[k]=1.
  - Latency 1: visible on rd_data in the cycle after the edge.
- Write conflict (NWR=2, same non-zero address, both enabled): port 1 wins; port 0's data is dropped. No error flag.
- Scoreboard (one busy bit per register), updated at the rising edge:
  - Any enabled write to register r clears busy[r].
  - bsy_set sets busy[bsy_addr].
  - Same edge, same address for set and clear: set wins (a new producer supersedes the retiring one).
  - bsy_set on an already-busy register keeps it busy; no counting.
  - A write to a non-busy register is legal and leaves busy at 0.
- rd_busy[i] = busy[rd_addr[i]].
- Widths: data passes through unmodified; no sign or zero extension inside the block.
- Out-of-range address: impossible because DEPTH is a power of two.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding is enabled.
  - If wr_en[k]=1 and wr_addr[k]==rd_addr[i]!=0, rd_data[i] = wr_data[k] in the same cycle.
  - The highest enabled port index wins, consistent with write priority.
  - rd_busy[i] is forced to 0 in that cycle unless bsy_set targets the same address.
- Not defined: no forwarding; the read returns the old value until the next cycle, and rd_busy reflects the stored bit.

Decomposition:
- Package regfile_mp_pkg holds:
  - the address-width helper function;
  - localparam ZERO_REG = 0;
  - the maximum port-count constants (4 read, 2 write) used by elaboration-time checks.
- One sub-module, regfile_mp_rdport, instantiated NRD times via generate.
  - Contains the read mux, the zero-register override and the bypass logic.
  - Its inputs are the storage array, the busy vector and the write buses.
- Storage, write priority and the scoreboard live in the top module.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, pulse rst_n low mid-cycle (no clk edge) → rd_data for r5 reads 0 immediately and rd_busy=0. After release, write 0x1234 to r5 → reads 0x1234 on the next cycle.
- Zero register: write 0xFFFFFFFF to r0 and bsy_set r0 → r0 reads 0 and rd_busy=0 on all ports.
- Write conflict (NWR=2): both ports write r7, port0 0xAAAA and port1 0x5555 → r7 reads 0x5555.
- Scoreboard: bsy_set r9 → rd_busy for r9 = 1 next cycle. Write r9 = 0x42 → busy cleared and r9 = 0x42. Repeat with bsy_set r9 and write r9 on the same edge → busy stays 1 and data = 0x42.
- Multi-read (NRD=4): all ports read r3 = 0x77 plus r0 → three ports give 0x77 and the r0 port gives 0.
- Bypass: write r12 = 0xCAFE and read r12 in the same cycle → 0xCAFE with REGFILE_MP_BYPASS_EN defined; old value (0) without it; both give 0xCAFE the following cycle.
